// File: rtl/poci_keys.sv
// POCI slave for the board push-buttons and slide switches: synchronises and
// debounces the pads, latches key-press events and raises a masked interrupt.
module poci_keys #(
    parameter int NKEYS    = 4,
    parameter int NSW      = 10,
    parameter int DEBOUNCE = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             psel,
    input  logic             penable,
    input  logic             pwrite,
    input  logic [31:0]      paddr,
    input  logic [31:0]      pwdata,
    output logic [31:0]      prdata,
    output logic             pready,
    output logic             perr,
    input  logic [NKEYS-1:0] key_n,
    input  logic [NSW-1:0]   sw,
    output logic             irq
);
    localparam int            CW       = $clog2(DEBOUNCE);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
    localparam logic [5:0]    W_KEY    = 6'h00;
    localparam logic [5:0]    W_EDGE   = 6'h01;
    localparam logic [5:0]    W_MASK   = 6'h02;
    localparam logic [5:0]    W_SW     = 6'h04;

    logic [NKEYS-1:0] key_s1_q, key_s2_q, key_sync;
    logic [NSW-1:0]   sw_s1_q, sw_s2_q;
    logic [CW-1:0]    cnt_q [NKEYS];
    logic [CW-1:0]    cnt_d [NKEYS];
    logic [NKEYS-1:0] key_stable_q, key_stable_d;
    logic [NKEYS-1:0] key_edge_q, key_edge_d, edge_clr;
    logic [NKEYS-1:0] key_mask_q, key_mask_d;
    logic [31:0]      prdata_q, prdata_d, rd_mux;
    logic             irq_q, irq_d;
    logic             mapped, setup, access, wr_en;
    logic [5:0]       word;
    logic             unused_bits;

    assign word        = paddr[7:2];
    assign setup       = psel & ~penable;
    assign access      = psel & penable;
    assign wr_en       = access & pwrite;
    // Key synchroniser idles at 1 (released); invert so 1 means pressed.
    assign key_sync    = ~key_s2_q;
    assign unused_bits = ^{paddr[31:8], paddr[1:0], pwdata[31:NKEYS]};

    always_comb begin
        for (int i = 0; i < NKEYS; i++) begin
            cnt_d[i]        = '0;
            key_stable_d[i] = key_stable_q[i];
            if (key_sync[i] != key_stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    key_stable_d[i] = key_sync[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        mapped = 1'b1;
        case (word)
            W_KEY:   rd_mux[NKEYS-1:0] = key_stable_q;
            W_EDGE:  rd_mux[NKEYS-1:0] = key_edge_q;
            W_MASK:  rd_mux[NKEYS-1:0] = key_mask_q;
            W_SW:    rd_mux[NSW-1:0]   = sw_s2_q;
            default: mapped            = 1'b0;
        endcase
    end

    // A new press sets its edge bit even when a W1C clear lands on the same edge.
    assign edge_clr   = (wr_en && word == W_EDGE) ? pwdata[NKEYS-1:0] : '0;
    assign key_edge_d = (key_edge_q & ~edge_clr) | (key_stable_d & ~key_stable_q);
    assign key_mask_d = (wr_en && word == W_MASK) ? pwdata[NKEYS-1:0] : key_mask_q;
    assign prdata_d   = (setup && !pwrite) ? rd_mux : prdata_q;
    assign irq_d      = |(key_edge_q & key_mask_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_s1_q     <= '1;
            key_s2_q     <= '1;
            sw_s1_q      <= '0;
            sw_s2_q      <= '0;
            key_stable_q <= '0;
            key_edge_q   <= '0;
            key_mask_q   <= '0;
            prdata_q     <= '0;
            irq_q        <= 1'b0;
            for (int i = 0; i < NKEYS; i++) cnt_q[i] <= '0;
        end else begin
            key_s1_q     <= key_n;
            key_s2_q     <= key_s1_q;
            sw_s1_q      <= sw;
            sw_s2_q      <= sw_s1_q;
            key_stable_q <= key_stable_d;
            key_edge_q   <= key_edge_d;
            key_mask_q   <= key_mask_d;
            prdata_q     <= prdata_d;
            irq_q        <= irq_d;
            for (int i = 0; i < NKEYS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign prdata = prdata_q;
    assign pready = 1'b1;
    assign perr   = access & ~mapped;
    assign irq    = irq_q;

endmodule

// File: tb/tb_poci_keys.sv
// Bench for poci_keys: directed and random traffic scored against a
// pad-history model of debounce, edge capture, mask and bus decode.
module tb_poci_keys;
    localparam int NKEYS = 4;
    localparam int NSW   = 10;
    localparam int DEB   = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0]      paddr = '0, pwdata = '0;
    logic [31:0]      prdata;
    logic             pready, perr, irq;
    logic [NKEYS-1:0] key_n = '1;
    logic [NSW-1:0]   sw = 10'h155;

    int n_tests = 0;
    int n_fail  = 0;

    poci_keys #(.NKEYS(NKEYS), .NSW(NSW), .DEBOUNCE(DEB)) dut (
        .clk(clk), .reset_n(reset_n), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .perr(perr), .key_n(key_n), .sw(sw), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_rd;
        logic [31:0] data;
        logic        err;
        logic [31:0] addr;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Reference model: a key level is accepted once the last DEB synchronised
    // samples all disagree with the accepted level; pads reach logic 2 edges late.
    logic [NKEYS-1:0] m_stable, m_edge, m_mask, m_used, m_new, m_clr;
    logic [NSW-1:0]   m_swu;
    logic             m_irq, m_mapped, m_all;
    logic [31:0]      m_mux;
    logic [NKEYS-1:0] rawq[$];
    logic [NKEYS-1:0] winq[$];
    logic [NSW-1:0]   swq[$];
    exp_t             m_e;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_stable = '0; m_edge = '0; m_mask = '0; m_irq = 1'b0;
            rawq.delete(); winq.delete(); swq.delete(); sbq.delete();
            rawq.push_back('0); rawq.push_back('0);
            swq.push_back('0);  swq.push_back('0);
        end else begin
            rawq.push_back(~key_n);
            m_used = rawq.pop_front();
            swq.push_back(sw);
            m_swu = swq.pop_front();
            m_mapped = 1'b1;
            m_mux = '0;
            case (paddr[7:2])
                6'd0:    m_mux = 32'(m_stable);
                6'd1:    m_mux = 32'(m_edge);
                6'd2:    m_mux = 32'(m_mask);
                6'd4:    m_mux = 32'(m_swu);
                default: m_mapped = 1'b0;
            endcase
            if (psel && !penable) begin
                m_e.is_rd = !pwrite; m_e.data = m_mux; m_e.err = !m_mapped; m_e.addr = paddr;
                sbq.push_back(m_e);
            end
            winq.push_back(m_used);
            if (winq.size() > DEB) void'(winq.pop_front());
            m_new = m_stable;
            if (winq.size() == DEB) begin
                for (int i = 0; i < NKEYS; i++) begin
                    m_all = 1'b1;
                    foreach (winq[j]) if (winq[j][i] == m_stable[i]) m_all = 1'b0;
                    if (m_all) m_new[i] = ~m_stable[i];
                end
            end
            m_clr = (psel && penable && pwrite && paddr[7:2] == 6'd1) ? pwdata[NKEYS-1:0] : '0;
            m_irq = |(m_edge & m_mask);
            m_edge = (m_edge & ~m_clr) | (m_new & ~m_stable);
            if (psel && penable && pwrite && paddr[7:2] == 6'd2) m_mask = pwdata[NKEYS-1:0];
            m_stable = m_new;
        end
    end

    // Monitor: compares every access phase against the scoreboard, irq every cycle.
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("reset_prdata", prdata, 32'h0);
            chk("reset_irq", 32'(irq), 32'h0);
        end else begin
            chk("irq", 32'(irq), 32'(m_irq));
            if (psel && penable) begin
                chk("pready", 32'(pready), 32'h1);
                if (sbq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL scoreboard_empty: access at addr 0x%08h with no expectation", paddr);
                end else begin
                    m_e = sbq.pop_front();
                    chk($sformatf("perr@%0h", m_e.addr), 32'(perr), 32'(m_e.err));
                    if (m_e.is_rd) chk($sformatf("prdata@%0h", m_e.addr), prdata, m_e.data);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic rd(input logic [31:0] a);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] addrs [8] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h20, 32'h106, 32'h13};

    initial begin
        // Reset with keys released and a switch pattern applied
        idle(3);
        reset_n = 1'b1;
        rd(32'h10); rd(32'h00); rd(32'h04); rd(32'h10);

        // Short pulse is discarded
        fork
            begin key_n[0] = 1'b0; idle(7); key_n[0] = 1'b1; end
            repeat (10) rd(32'h00);
        join
        idle(12);

        // Accepted press with mask enabled, sampled at both read parities
        wr(32'h08, 32'h1);
        fork
            begin key_n[0] = 1'b0; idle(10); end
            repeat (7) rd(32'h00);
        join
        rd(32'h04);
        wr(32'h04, 32'h0); rd(32'h04);
        wr(32'h04, 32'h1); rd(32'h04); idle(2);

        // Release: KEY clears, EDGE stays clear
        fork
            begin key_n[0] = 1'b1; idle(12); end
            begin idle(1); repeat (6) rd(32'h00); end
        join
        rd(32'h04);

        // Bounce: acceptance counted from the final low
        fork
            begin key_n[0] = 1'b0; idle(3); key_n[0] = 1'b1; idle(2); key_n[0] = 1'b0; idle(14); end
            repeat (9) rd(32'h00);
        join
        rd(32'h04); wr(32'h04, 32'h1);
        key_n[0] = 1'b1; idle(12);

        // Clear of bit 1 lands on the edge key1 is accepted: set wins
        key_n[1] = 1'b0; idle(8);
        wr(32'h04, 32'h2); rd(32'h04);
        key_n[1] = 1'b1; idle(12); wr(32'h04, 32'hF);

        // Keys 0 and 3 together
        key_n = 4'b0110; idle(12); rd(32'h04); rd(32'h00);
        key_n = 4'hF; idle(12); wr(32'h04, 32'hF);

        // Bus decode and error responses, back-to-back reads
        sw = 10'h2A7; idle(3);
        rd(32'h0C); wr(32'h20, 32'hFFFF_FFFF); rd(32'h08); rd(32'h04);
        wr(32'h00, 32'hF); rd(32'h00); rd(32'h10); rd(32'h02); rd(32'h14);

        // Random pads and random bus traffic
        fork
            repeat (60) begin
                key_n = NKEYS'($urandom);
                if ($urandom_range(0, 3) == 0) sw = NSW'($urandom);
                idle($urandom_range(1, DEB + 6));
            end
            repeat (200) begin
                if ($urandom_range(0, 1) == 0) rd(addrs[$urandom_range(0, 7)]);
                else wr(addrs[$urandom_range(0, 7)], $urandom);
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            end
        join
        key_n = 4'hF; idle(14);

        // Reset abandoning an access while a key is held
        wr(32'h08, 32'hF);
        key_n[2] = 1'b0; idle(12);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h04;
        @(posedge clk); #1 penable = 1'b1;
        #2 reset_n = 1'b0; psel = 1'b0; penable = 1'b0;
        idle(3);
        reset_n = 1'b1;
        rd(32'h04); rd(32'h08); rd(32'h00);
        idle(10);
        wr(32'h08, 32'h4); rd(32'h04); rd(32'h00); idle(3);
        key_n = 4'hF; idle(3);

        chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/poci_keys.md
Name: poci_keys

Overview:
- POCI slave for the keys/switches window at base_keys (0x80001000), serving addr_key (offset 0x00) and addr_sw (offset 0x10).
- Sits between the board push-buttons/slide switches and the core's POCI interconnect, next to the LED peripheral at base_leds.
- Synchronises and debounces the raw pad inputs and captures key-press events in a sticky register.
- Raises an interrupt request for key presses that are enabled in the mask register.

Parameters:
- NKEYS, 4, number of push-buttons
- NSW, 10, number of slide switches
- DEBOUNCE, 50000, cycles of stable mismatch before a key level is accepted (1 ms at 50 MHz); minimum 2

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- psel  in  1  slave select (interconnect decodes the base_keys window)
- penable  in  1  access phase
- pwrite  in  1  1 = write
- paddr  in  32  byte address; only bits [7:0] are decoded here
- pwdata  in  32  write data
- prdata  out  32  read data
- pready  out  1  ready
- perr  out  1  error response
- key_n  in  NKEYS  raw buttons, active-low, asynchronous to clk
- sw  in  NSW  raw switches, asynchronous to clk
- irq  out  1  level interrupt request

Behaviour:
- Clocking and reset: one clock, clk; reset_n is asynchronous and active-low.
- All state resets to 0: synchronisers, debounce counters, key_stable, key_edge, key_mask, prdata, irq. The synchroniser flops for key_n reset to 1 (released), so no spurious press is seen after reset.
- Input path: key_n and sw each pass through a 2-flop synchroniser. key_sync is the inverted synchroniser output (1 = pressed).
- Debounce, per key:
  - counter width is clog2(DEBOUNCE).
  - If key_sync == key_stable, the counter clears to 0.
  - Otherwise the counter increments. When it equals DEBOUNCE-1 and the mismatch is still present, key_stable flips to key_sync and the counter clears.
  - Net latency from raw pad change to visible key_stable is 2 + DEBOUNCE cycles. Any glitch shorter than DEBOUNCE cycles is discarded and restarts the count.
- Switches: no debounce. sw_stable is the synchroniser output, with 2 cycles of latency.
- Edge capture:
  - A 0->1 transition of key_stable[i] sets key_edge[i].
  - A write to offset 0x04 clears key_edge bits where pwdata is 1 (write-one-to-clear).
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- irq is registered: irq <= |(key_edge & key_mask). It rises 1 cycle after the edge bit sets.
- Register map (offset from base_keys):
  - 0x00 KEY, RO: {0, key_stable}
  - 0x04 EDGE, R/W1C: {0, key_edge}
  - 0x08 MASK, RW: {0, key_mask}; only bits NKEYS-1:0 are stored
  - 0x10 SW, RO: {0, sw_stable}
  - Writes to RO offsets are ignored with perr = 0.
  - Any other offset: reads return 0, writes are ignored, and perr = 1 in the access phase.
  - paddr[1:0] is ignored (word access only).
- POCI handshake:
  - Setup phase: psel=1, penable=0. Access phase: psel=1, penable=1.
  - pready is constant 1 (zero wait states).
  - Read: on the clk edge ending the setup phase, prdata <= mux(offset), so prdata is valid throughout the access phase. prdata holds its value otherwise.
  - Write: register update on the clk edge ending the access phase.
  - perr is combinational, asserted only when psel & penable and the offset is unmapped; 0 otherwise.
  - A read of EDGE in the same cycle an edge sets returns the pre-set value; the bit is visible on the next read.
- Reset mid-operation: an in-flight access is abandoned and all state returns to reset values immediately. The interconnect must restart with a setup phase.

Test Plan:
- Reset: hold reset_n=0 with key_n=4'hF and sw=10'h155, then release.
  - prdata=0, irq=0 during reset.
  - Read 0x00 -> 0 and 0x04 -> 0.
  - Read 0x10 -> 0x155 from 2 cycles after release.
- Debounce, with DEBOUNCE=8:
  - Pulse key_n[0]=0 for 7 cycles -> KEY stays 0.
  - Hold key_n[0]=0 for 10 cycles -> KEY=0x1 exactly 10 cycles after the falling pad edge, and EDGE=0x1.
  - Bounce (3 cycles low, 2 high, then low) -> acceptance is timed from the final low.
- Edge and IRQ: write MASK=0x1, then press key0 -> irq=1 one cycle after EDGE[0]=1.
  - Write EDGE=0x1 -> EDGE=0, and irq=0 on the next cycle.
  - Write EDGE=0x0 -> no change.
- Simultaneous set and clear: time a W1C write to EDGE with pwdata=0x2 to end on the same cycle key1 becomes stable -> EDGE[1]=1 remains.
- Release: key released -> KEY bit returns to 0 after 2+DEBOUNCE cycles, with no EDGE set. Multi-key press of keys 0 and 3 -> EDGE=0x9.
- Bus errors: read 0x0C -> prdata=0, perr=1 in the access phase. Write 0x20 -> perr=1, no state change. Write 0x00 -> perr=0, KEY unchanged. Back-to-back reads of 0x00 then 0x10 with no idle cycle -> correct data each time.
